// File: rtl/skid_pkg.sv
// Shared definitions for the two-entry skid buffer.
// The state encoding doubles as the occupancy count.
package skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/skid_buffer_reg_en.sv
// Plain data register: async active-high reset to zero, loads when en is high.
module reg_en #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: a main output register plus a skid register that
// absorbs the word arriving in the cycle downstream stalls.
module skid_buffer
  import skid_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       count
);

  // Handshake: a word moves on a side only when valid && ready are both high
  // at posedge clk. in_ready depends on registered state (and rst) only, so
  // there is no combinational path from out_ready back to in_ready.

  state_t           state;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  assign count     = state;
  assign out_valid = (state != EMPTY);
  assign in_ready  = !rst && (state != FULL);

  always_comb begin
    main_en = 1'b0;
    skid_en = 1'b0;
    main_d  = in_data;
    if (!flush) begin
      unique case (state)
        EMPTY: main_en = in_valid;
        BUSY: begin
          main_en = in_valid && out_ready;
          skid_en = in_valid && !out_ready;
        end
        FULL: begin
          main_en = out_ready;
          main_d  = skid_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (in_valid) state <= BUSY;
        BUSY: begin
          if (in_valid && !out_ready)      state <= FULL;
          else if (!in_valid && out_ready) state <= EMPTY;
        end
        FULL:    if (out_ready) state <= BUSY;
        default: state <= EMPTY;
      endcase
    end
  end

  reg_en #(.WIDTH(WIDTH)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (out_data)
  );

  reg_en #(.WIDTH(WIDTH)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_q)
  );

endmodule
